// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: freeze/flush sequencer for the PC, IF/ID, ID/EXE and
// EXE/MEM stage registers. Priority is memory stall > taken branch > RAW hazard.
// A small FSM tracks multi-cycle memory accesses and raises a sticky watchdog
// flag (mem_timeout) when one runs MEM_TIMEOUT cycles in WAIT.
// Optional macro STALL_STATS_EN adds saturating 32-bit stall/flush counters.
module pipeline_stall_ctrl #(
   parameter int unsigned FORWARDING_EN = 1,
   parameter int unsigned MEM_TIMEOUT   = 255,
   parameter int unsigned CNT_W         = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       branch_taken,
   input  logic [3:0] id_src1,
   input  logic [3:0] id_src2,
   input  logic       id_has_src1,
   input  logic       id_has_src2,
   input  logic       exe_wb_en,
   input  logic       exe_mem_r_en,
   input  logic [3:0] exe_dest,
   input  logic       mem_wb_en,
   input  logic [3:0] mem_dest,
   input  logic       mem_req,
   input  logic       mem_ready,
   output logic       pc_freeze,
   output logic       if_id_freeze,
   output logic       if_id_flush,
   output logic       id_exe_freeze,
   output logic       id_exe_flush,
   output logic       exe_mem_freeze,
   output logic       mem_stall,
   output logic       mem_timeout
`ifdef STALL_STATS_EN
   ,
   output logic [31:0] stat_mem_cycles,
   output logic [31:0] stat_hazard_cycles,
   output logic [31:0] stat_flushes
`endif
);

   typedef enum logic {IDLE, WAIT} state_t;

   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             timeout_q;

   logic src1_hit, src2_hit, hazard;
   logic stall_raw, hazard_apply, flush_apply;

   // RAW hazard detection on the ID instruction's source registers
   always_comb begin
      src1_hit = id_has_src1 & exe_wb_en & (exe_dest == id_src1);
      src2_hit = id_has_src2 & exe_wb_en & (exe_dest == id_src2);
      if (FORWARDING_EN != 0) begin
         // Forwarding covers everything except a load whose data is not back yet.
         src1_hit = src1_hit & exe_mem_r_en;
         src2_hit = src2_hit & exe_mem_r_en;
      end else begin
         src1_hit = src1_hit | (id_has_src1 & mem_wb_en & (mem_dest == id_src1));
         src2_hit = src2_hit | (id_has_src2 & mem_wb_en & (mem_dest == id_src2));
      end
      hazard = src1_hit | src2_hit;
   end

   // Prioritised freeze/flush generation; reset silences everything but the watchdog flag
   always_comb begin
      pc_freeze      = 1'b0;
      if_id_freeze   = 1'b0;
      if_id_flush    = 1'b0;
      id_exe_freeze  = 1'b0;
      id_exe_flush   = 1'b0;
      exe_mem_freeze = 1'b0;
      mem_stall      = 1'b0;
      hazard_apply   = 1'b0;
      flush_apply    = 1'b0;
      stall_raw      = mem_req & ~mem_ready;
      if (!rst) begin
         if (stall_raw) begin
            mem_stall      = 1'b1;
            pc_freeze      = 1'b1;
            if_id_freeze   = 1'b1;
            id_exe_freeze  = 1'b1;
            exe_mem_freeze = 1'b1;
         end else if (branch_taken) begin
            // A branch held through a memory stall lands here on the release cycle.
            flush_apply  = 1'b1;
            if_id_flush  = 1'b1;
            id_exe_flush = 1'b1;
         end else if (hazard) begin
            hazard_apply = 1'b1;
            pc_freeze    = 1'b1;
            if_id_freeze = 1'b1;
            id_exe_flush = 1'b1;
         end
      end
   end

   assign mem_timeout = timeout_q;

   // Memory-wait FSM with saturating wait counter and sticky timeout flag
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (mem_req && !mem_ready) begin
                  state_q <= WAIT;
                  cnt_q   <= CNT_W'(1);
               end
            end
            WAIT: begin
               if (mem_ready || !mem_req) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else begin
                  if (cnt_q == CNT_LIMIT) begin
                     timeout_q <= 1'b1;
                  end
                  if (cnt_q != '1) begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

`ifdef STALL_STATS_EN
   logic [31:0] stat_mem_q, stat_hazard_q, stat_flush_q;

   // Saturating event counters for stall and flush cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_mem_q    <= '0;
         stat_hazard_q <= '0;
         stat_flush_q  <= '0;
      end else begin
         if (mem_stall && stat_mem_q != '1) begin
            stat_mem_q <= stat_mem_q + 32'd1;
         end
         if (hazard_apply && stat_hazard_q != '1) begin
            stat_hazard_q <= stat_hazard_q + 32'd1;
         end
         if (flush_apply && stat_flush_q != '1) begin
            stat_flush_q <= stat_flush_q + 32'd1;
         end
      end
   end

   assign stat_mem_cycles    = stat_mem_q;
   assign stat_hazard_cycles = stat_hazard_q;
   assign stat_flushes       = stat_flush_q;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: one instance with forwarding
// (MEM_TIMEOUT=5) and one without (MEM_TIMEOUT=7) share the same stimulus.
// Expected output vectors come from a behavioural model and go through queues.
module tb_pipeline_stall_ctrl;

   localparam int unsigned TO1 = 5;
   localparam int unsigned TO0 = 7;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, branch_taken, id_has_src1, id_has_src2;
   logic       exe_wb_en, exe_mem_r_en, mem_wb_en, mem_req, mem_ready;
   logic [3:0] id_src1, id_src2, exe_dest, mem_dest;

   // {pc_freeze, if_id_freeze, if_id_flush, id_exe_freeze, id_exe_flush,
   //  exe_mem_freeze, mem_stall, mem_timeout}
   logic [7:0] obs1, obs0;

`ifdef STALL_STATS_EN
   logic [31:0] s1_mem, s1_hz, s1_fl, s0_mem, s0_hz, s0_fl;
`endif

   pipeline_stall_ctrl #(.FORWARDING_EN(1), .MEM_TIMEOUT(TO1), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .branch_taken(branch_taken),
      .id_src1(id_src1), .id_src2(id_src2),
      .id_has_src1(id_has_src1), .id_has_src2(id_has_src2),
      .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .exe_dest(exe_dest),
      .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
      .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_freeze(obs1[7]), .if_id_freeze(obs1[6]), .if_id_flush(obs1[5]),
      .id_exe_freeze(obs1[4]), .id_exe_flush(obs1[3]), .exe_mem_freeze(obs1[2]),
      .mem_stall(obs1[1]), .mem_timeout(obs1[0])
`ifdef STALL_STATS_EN
      , .stat_mem_cycles(s1_mem), .stat_hazard_cycles(s1_hz), .stat_flushes(s1_fl)
`endif
   );

   pipeline_stall_ctrl #(.FORWARDING_EN(0), .MEM_TIMEOUT(TO0), .CNT_W(16)) dut0 (
      .clk(clk), .rst(rst), .branch_taken(branch_taken),
      .id_src1(id_src1), .id_src2(id_src2),
      .id_has_src1(id_has_src1), .id_has_src2(id_has_src2),
      .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .exe_dest(exe_dest),
      .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
      .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_freeze(obs0[7]), .if_id_freeze(obs0[6]), .if_id_flush(obs0[5]),
      .id_exe_freeze(obs0[4]), .id_exe_flush(obs0[3]), .exe_mem_freeze(obs0[2]),
      .mem_stall(obs0[1]), .mem_timeout(obs0[0])
`ifdef STALL_STATS_EN
      , .stat_mem_cycles(s0_mem), .stat_hazard_cycles(s0_hz), .stat_flushes(s0_fl)
`endif
   );

   typedef struct packed {
      logic       h1;
      logic [3:0] s1;
      logic       h2;
      logic [3:0] s2;
      logic       ewb;
      logic       er;
      logic [3:0] ed;
      logic       mwb;
      logic [3:0] md;
   } hz_t;

   int checks   = 0;
   int failures = 0;

   logic [7:0] exp1_q[$];
   logic [7:0] exp0_q[$];
   logic [7:0] e1, e0;

   bit          m_wait = 1'b0;
   int unsigned m_cnt  = 0;
   logic        m_to1  = 1'b0;
   logic        m_to0  = 1'b0;
   logic [31:0] m_smem = '0;
   logic [31:0] m_shz  = '0;
   logic [31:0] m_sfl  = '0;

   function automatic logic model_hz(input bit fwd);
      logic c1, c2;
      c1 = id_has_src1 && exe_wb_en && (exe_dest == id_src1) && (!fwd || exe_mem_r_en);
      c2 = id_has_src2 && exe_wb_en && (exe_dest == id_src2) && (!fwd || exe_mem_r_en);
      if (!fwd) begin
         c1 = c1 || (id_has_src1 && mem_wb_en && (mem_dest == id_src1));
         c2 = c2 || (id_has_src2 && mem_wb_en && (mem_dest == id_src2));
      end
      return c1 || c2;
   endfunction

   function automatic logic [7:0] model_out(input bit fwd, input logic to);
      logic [7:0] o;
      o = {7'b0000000, to};
      if (!rst) begin
         if (mem_req && !mem_ready)  o[7:1] = 7'b1101011;
         else if (branch_taken)      o[7:1] = 7'b0010100;
         else if (model_hz(fwd))     o[7:1] = 7'b1100100;
      end
      return o;
   endfunction

   task automatic model_update();
      if (rst) begin
         m_wait = 1'b0; m_cnt = 0; m_to1 = 1'b0; m_to0 = 1'b0;
         m_smem = '0; m_shz = '0; m_sfl = '0;
      end else begin
         if (mem_req && !mem_ready) begin
            if (m_smem != 32'hFFFF_FFFF) m_smem = m_smem + 1;
         end else if (branch_taken) begin
            if (m_sfl != 32'hFFFF_FFFF) m_sfl = m_sfl + 1;
         end else if (model_hz(1'b1)) begin
            if (m_shz != 32'hFFFF_FFFF) m_shz = m_shz + 1;
         end
         if (!m_wait) begin
            if (mem_req && !mem_ready) begin m_wait = 1'b1; m_cnt = 1; end
         end else if (mem_ready || !mem_req) begin
            m_wait = 1'b0; m_cnt = 0;
         end else begin
            if (m_cnt == TO1) m_to1 = 1'b1;
            if (m_cnt == TO0) m_to0 = 1'b1;
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
         end
      end
   endtask

   task automatic set_ctl(input logic r, input logic b, input logic req, input logic rdy);
      rst = r; branch_taken = b; mem_req = req; mem_ready = rdy;
   endtask

   task automatic set_hz(input hz_t h);
      id_has_src1 = h.h1; id_src1 = h.s1; id_has_src2 = h.h2; id_src2 = h.s2;
      exe_wb_en = h.ewb; exe_mem_r_en = h.er; exe_dest = h.ed;
      mem_wb_en = h.mwb; mem_dest = h.md;
   endtask

   task automatic push_exp();
      exp1_q.push_back(model_out(1'b1, m_to1));
      exp0_q.push_back(model_out(1'b0, m_to0));
      @(negedge clk);
   endtask

   task automatic adv();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic test_reset();
      set_hz('0);
      for (int i = 0; i < 2; i++) begin
         set_ctl(1'b1, 1'b1, 1'b1, 1'b0);
         push_exp();
         e1 = exp1_q.pop_front(); e0 = exp0_q.pop_front();
         checks++;
         if (obs1 !== e1) begin failures++; $display("FAIL reset[%0d] fwd1 got=%b exp=%b", i, obs1, e1); end
         checks++;
         if (obs0 !== e0) begin failures++; $display("FAIL reset[%0d] fwd0 got=%b exp=%b", i, obs0, e0); end
         adv();
      end
   endtask

   task automatic test_hazard();
      hz_t tbl[8];
      tbl[0] = '{1'b1, 4'd3, 1'b0, 4'd0, 1'b1, 1'b1, 4'd3, 1'b0, 4'd0};
      tbl[1] = '{1'b1, 4'd3, 1'b0, 4'd0, 1'b1, 1'b0, 4'd3, 1'b0, 4'd0};
      tbl[2] = '{1'b0, 4'd1, 1'b1, 4'd7, 1'b1, 1'b1, 4'd7, 1'b0, 4'd0};
      tbl[3] = '{1'b0, 4'd3, 1'b0, 4'd0, 1'b1, 1'b1, 4'd3, 1'b0, 4'd0};
      tbl[4] = '{1'b1, 4'd3, 1'b0, 4'd0, 1'b1, 1'b1, 4'd4, 1'b0, 4'd0};
      tbl[5] = '{1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 1'b1, 4'd3, 1'b0, 4'd0};
      tbl[6] = '{1'b1, 4'd5, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd5};
      tbl[7] = '{1'b0, 4'd0, 1'b1, 4'd5, 1'b0, 1'b0, 4'd0, 1'b0, 4'd5};
      for (int i = 0; i < 8; i++) begin
         set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
         set_hz(tbl[i]);
         push_exp();
         e1 = exp1_q.pop_front(); e0 = exp0_q.pop_front();
         checks++;
         if (obs1 !== e1) begin failures++; $display("FAIL hazard[%0d] fwd1 got=%b exp=%b", i, obs1, e1); end
         checks++;
         if (obs0 !== e0) begin failures++; $display("FAIL hazard[%0d] fwd0 got=%b exp=%b", i, obs0, e0); end
         adv();
      end
   endtask

   task automatic test_branch();
      hz_t lu;
      lu = '{1'b1, 4'd3, 1'b0, 4'd0, 1'b1, 1'b1, 4'd3, 1'b0, 4'd0};
      for (int i = 0; i < 3; i++) begin
         set_hz(i == 0 ? hz_t'('0) : lu);
         set_ctl(1'b0, (i != 2), 1'b0, 1'b0);
         push_exp();
         e1 = exp1_q.pop_front(); e0 = exp0_q.pop_front();
         checks++;
         if (obs1 !== e1) begin failures++; $display("FAIL branch[%0d] fwd1 got=%b exp=%b", i, obs1, e1); end
         checks++;
         if (obs0 !== e0) begin failures++; $display("FAIL branch[%0d] fwd0 got=%b exp=%b", i, obs0, e0); end
         adv();
      end
      set_hz('0);
   endtask

   // nstall waiting cycles, then one cycle ending the access (ready or abort), then idle
   task automatic test_mem(input string name, input int nstall, input logic br,
                           input logic abort);
      for (int i = 0; i < nstall + 2; i++) begin
         if (i < nstall)       set_ctl(1'b0, br, 1'b1, 1'b0);
         else if (i == nstall) set_ctl(1'b0, br, !abort, !abort);
         else                  set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
         push_exp();
         e1 = exp1_q.pop_front(); e0 = exp0_q.pop_front();
         checks++;
         if (obs1 !== e1) begin failures++; $display("FAIL %s[%0d] fwd1 got=%b exp=%b", name, i, obs1, e1); end
         checks++;
         if (obs0 !== e0) begin failures++; $display("FAIL %s[%0d] fwd0 got=%b exp=%b", name, i, obs0, e0); end
         checks++;
         if (dut.cnt_q !== m_cnt[15:0]) begin
            failures++; $display("FAIL %s[%0d] cnt got=%0d exp=%0d", name, i, dut.cnt_q, m_cnt);
         end
         adv();
      end
   endtask

   task automatic test_timeout();
      for (int i = 0; i < 14; i++) begin
         if (i < 9)       set_ctl(1'b0, 1'b0, 1'b1, 1'b0);
         else if (i == 9) set_ctl(1'b0, 1'b0, 1'b1, 1'b1);
         else if (i == 12) set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
         else             set_ctl(1'b0, (i == 11), 1'b0, 1'b0);
`ifdef STALL_STATS_EN
         if (i == 12) begin
            checks++;
            if ({s1_mem, s1_hz, s1_fl} !== {m_smem, m_shz, m_sfl}) begin
               failures++;
               $display("FAIL stats_accum got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                        s1_mem, s1_hz, s1_fl, m_smem, m_shz, m_sfl);
            end
         end
`endif
         push_exp();
         e1 = exp1_q.pop_front(); e0 = exp0_q.pop_front();
         checks++;
         if (obs1 !== e1) begin failures++; $display("FAIL timeout[%0d] fwd1 got=%b exp=%b", i, obs1, e1); end
         checks++;
         if (obs0 !== e0) begin failures++; $display("FAIL timeout[%0d] fwd0 got=%b exp=%b", i, obs0, e0); end
         adv();
      end
   endtask

   task automatic test_reset_mid_wait();
      for (int i = 0; i < 4; i++) begin
         if (i < 2)  set_ctl((i == 1), 1'b0, 1'b1, 1'b0);
         else        set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
         push_exp();
         e1 = exp1_q.pop_front(); e0 = exp0_q.pop_front();
         checks++;
         if (obs1 !== e1) begin failures++; $display("FAIL rst_wait[%0d] fwd1 got=%b exp=%b", i, obs1, e1); end
         checks++;
         if (obs0 !== e0) begin failures++; $display("FAIL rst_wait[%0d] fwd0 got=%b exp=%b", i, obs0, e0); end
         checks++;
         if (dut.cnt_q !== m_cnt[15:0]) begin
            failures++; $display("FAIL rst_wait[%0d] cnt got=%0d exp=%0d", i, dut.cnt_q, m_cnt);
         end
`ifdef STALL_STATS_EN
         if (i == 2) begin
            checks++;
            if ({s1_mem, s1_hz, s1_fl} !== 96'd0) begin
               failures++;
               $display("FAIL stats_cleared got=%0d/%0d/%0d exp=0/0/0", s1_mem, s1_hz, s1_fl);
            end
         end
`endif
         adv();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      set_hz('0);
      set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
      adv();
      test_reset();
      test_hazard();
      test_branch();
      test_mem("mem_wait", 4, 1'b0, 1'b0);
      test_mem("br_stall", 3, 1'b1, 1'b0);
      test_mem("abort", 2, 1'b0, 1'b1);
      test_timeout();
      test_reset_mid_wait();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Central sequencer for the pipeline registers: generates freeze and flush for the PC, IF/ID, ID/EXE and EXE/MEM stage registers.
- Combines three causes of stalls and flushes:
  - a taken branch resolved in EXE;
  - a RAW data hazard on the instruction in ID;
  - a multi-cycle cache/SRAM access in MEM, tracked by a small FSM with a timeout watchdog.
- Sits beside the hazard/forwarding logic; its outputs drive the freeze/flush pins of every stage register.

Parameters:
- FORWARDING_EN, 1, 1 = forwarding unit present, so only a load-use in EXE causes a hazard stall; 0 = any pending write in EXE or MEM to a source register stalls.
- MEM_TIMEOUT, 255, MEM-wait cycles before mem_timeout sets; legal range 1..65535.
- CNT_W, 16, width of the wait counter (≥ clog2(MEM_TIMEOUT+1)).

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- branch_taken, input, 1, taken branch in EXE.
- id_src1, input, 4, ID source register 1.
- id_src2, input, 4, ID source register 2.
- id_has_src1, input, 1, src1 is valid.
- id_has_src2, input, 1, src2 is valid.
- exe_wb_en, input, 1, EXE instruction writes back.
- exe_mem_r_en, input, 1, EXE instruction is a load.
- exe_dest, input, 4, EXE destination register.
- mem_wb_en, input, 1, MEM instruction writes back.
- mem_dest, input, 4, MEM destination register.
- mem_req, input, 1, MEM-stage read or write active.
- mem_ready, input, 1, cache/SRAM completes the access this cycle.
- pc_freeze, output, 1, hold PC.
- if_id_freeze, output, 1, hold IF/ID.
- if_id_flush, output, 1, clear IF/ID.
- id_exe_freeze, output, 1, hold ID/EXE.
- id_exe_flush, output, 1, clear ID/EXE (bubble).
- exe_mem_freeze, output, 1, hold EXE/MEM.
- mem_stall, output, 1, memory stall active.
- mem_timeout, output, 1, sticky watchdog error.

Behaviour:
- All control outputs are combinational from the inputs and state, so they take effect in the same cycle. While rst=1, every output except mem_timeout is forced to 0.
- Memory stall:
  - mem_stall = mem_req & ~mem_ready.
  - When mem_stall=1: pc_freeze, if_id_freeze, id_exe_freeze and exe_mem_freeze are all 1, and both flushes are 0.
  - mem_stall has the highest priority and masks branch and hazard effects.
- Branch flush:
  - When branch_taken=1 and mem_stall=0: if_id_flush=1 and id_exe_flush=1; pc_freeze, if_id_freeze and id_exe_freeze are 0, so the PC loads the branch target.
  - A branch held in EXE under a memory stall flushes exactly once, in the first cycle after the stall releases.
- Hazard:
  - Each source check is (id_has_srcN & exe_wb_en & exe_dest==id_srcN), plus, only when FORWARDING_EN=0, (id_has_srcN & mem_wb_en & mem_dest==id_srcN).
  - When FORWARDING_EN=1, the EXE term additionally requires exe_mem_r_en.
  - hazard = src1 check OR src2 check.
  - When hazard=1, branch_taken=0 and mem_stall=0: pc_freeze=1, if_id_freeze=1, id_exe_flush=1; all other outputs 0.
- Priority: mem_stall > branch_taken > hazard.
- FSM (reset state IDLE):
  - IDLE: if mem_req & ~mem_ready, go to WAIT and set cnt=1. Otherwise stay in IDLE.
  - WAIT: if mem_ready, go to IDLE and set cnt=0. Otherwise cnt = cnt+1, saturating at all-ones.
  - WAIT when mem_req drops without mem_ready (aborted access): go to IDLE, cnt=0, mem_timeout unchanged.
  - mem_timeout sets when in WAIT with cnt==MEM_TIMEOUT and mem_ready=0. It stays set until rst; stall behaviour is unaffected.
- Reset values: state=IDLE, cnt=0, mem_timeout=0. Reset mid-WAIT returns the FSM to IDLE on the next edge and drops all freezes immediately.

Optional Feature:
- Macro STALL_STATS_EN.
- Defined: adds three outputs, each 32 bits, saturating and cleared by rst:
  - stat_mem_cycles, incremented every cycle mem_stall=1;
  - stat_hazard_cycles, incremented every cycle the hazard stall is applied;
  - stat_flushes, incremented every cycle the branch flush is applied.
- Not defined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Load-use hazard, FORWARDING_EN=1: exe_mem_r_en=1, exe_wb_en=1, exe_dest=3, id_src1=3, id_has_src1=1 → pc_freeze=1, if_id_freeze=1, id_exe_flush=1 for that cycle; the same case with exe_mem_r_en=0 → all outputs 0.
- Branch with simultaneous hazard: branch_taken=1 while a hazard condition is present → if_id_flush=1, id_exe_flush=1, pc_freeze=0.
- Memory wait of 4 cycles: mem_req=1, mem_ready=0 for 4 cycles, then mem_ready=1 → all four freezes=1 for 4 cycles, FSM returns to IDLE, cnt=0.
- Branch under memory stall: branch_taken=1 held through a 3-cycle memory stall → flushes stay 0 during the stall; both flushes=1 exactly in cycle 4.
- Timeout, MEM_TIMEOUT=5: mem_ready held 0 → mem_timeout=1 after the 5th WAIT cycle; it stays 1 after mem_ready and clears only on rst.
- Reset mid-WAIT: rst=1 during cycle 2 of a memory wait → outputs are 0 that cycle and FSM=IDLE after the edge; with STALL_STATS_EN defined, all statistics counters read 0.
